// File: rtl/phy_mem_arbiter.sv
// phy_mem_arbiter: two-port (fetch/data) arbiter in front of a single physical memory controller
module phy_mem_arbiter #(
    parameter int READ_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,
    output logic        dm_err,
    output logic        mem_is_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    input  logic        mem_busy
);
    typedef enum logic [2:0] {IDLE, RD_WAIT, WR_ISSUE, WR_WAIT, DONE} state_t;
    state_t      state, state_n;
    logic        owner, last_owner, err_q;
    logic [2:0]  cnt;
    logic [31:0] addr_q, wdata_q;
    logic        grant_any, grant_dm, sel_we, sel_bad;
    logic [31:0] sel_addr;
    assign grant_any = if_req || dm_req;
    assign grant_dm  = dm_req && (!if_req || !last_owner);
    assign sel_addr  = grant_dm ? dm_addr : if_addr;
    assign sel_we    = grant_dm && dm_we;
    assign sel_bad   = sel_addr[1:0] != 2'b00;
    assign mem_is_write = state == WR_ISSUE;
    assign mem_addr     = addr_q;
    assign mem_data_in  = wdata_q;
    assign if_ack       = state == DONE && !owner;
    assign dm_ack       = state == DONE && owner;
    assign dm_err       = dm_ack && err_q;
    // state register; reset abandons any transaction immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end
    // next-state: unaligned grants skip memory, DONE always returns to IDLE without regranting
    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (grant_any) state_n = sel_bad ? DONE : sel_we ? WR_ISSUE : RD_WAIT;
            RD_WAIT:  if (cnt == 3'd0 && !mem_busy) state_n = DONE;
            WR_ISSUE: state_n = WR_WAIT;
            WR_WAIT:  if (!mem_busy) state_n = DONE;
            DONE:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end
    // transaction latches, read-wait counter, per-port read data and round-robin history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner      <= 1'b0;
            last_owner <= 1'b0;
            err_q      <= 1'b0;
            cnt        <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            if (state == IDLE && grant_any) begin
                owner   <= grant_dm;
                err_q   <= sel_bad;
                addr_q  <= sel_addr;
                wdata_q <= grant_dm ? dm_wdata : '0;
                cnt     <= 3'(READ_WAIT);
            end
            if (state == RD_WAIT) begin
                if (cnt != 3'd0) cnt <= cnt - 3'd1;
                else if (!mem_busy && owner) dm_rdata <= mem_data_out;
                else if (!mem_busy) if_rdata <= mem_data_out;
            end
            if (state == DONE) last_owner <= owner;
        end
    end
endmodule

// File: tb/tb_phy_mem_arbiter.sv
// tb_phy_mem_arbiter: table-driven scoreboard bench for phy_mem_arbiter (READ_WAIT = 1)
module tb_phy_mem_arbiter;
    localparam logic [31:0] K = 32'hDEAD_BFEF;
    logic        clk = 1'b0, rst = 1'b0;
    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_data_in, mem_data_out;
    logic        if_ack, dm_ack, dm_err, mem_is_write, mem_busy;
    int          busy_len = 0, busy_left = 0, cyc = 0, strobes = 0;
    int          vecs = 0, fails = 0;
    logic [31:0] last_rd [2];

    typedef struct {
        logic        is_dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          busy;
        int          lat;
        logic        err;
        int          strobes;
    } vec_t;
    typedef struct {
        logic        port;
        logic        err;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;
        int          strobes;
    } exp_t;
    exp_t q[$];
    vec_t vt[10];

    phy_mem_arbiter #(.READ_WAIT(1)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_err(dm_err),
        .mem_is_write(mem_is_write), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .mem_busy(mem_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_data_out = mem_addr ^ K;
    assign mem_busy = busy_left != 0;
    always @(posedge clk or negedge rst) begin
        if (!rst) busy_left <= 0;
        else if (mem_is_write) busy_left <= busy_len;
        else if (busy_left != 0) busy_left <= busy_left - 1;
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mem_is_write) begin
            strobes++;
            if (q.size() > 0) begin
                chk("strobe_addr", mem_addr, q[0].addr);
                chk("strobe_wdata", mem_data_in, q[0].wdata);
            end
        end
        if (dm_err && !dm_ack) chk("err_without_ack", 32'(dm_err), 32'd0);
        if (if_ack || dm_ack) begin
            chk("ack_exclusive", 32'(if_ack & dm_ack), 32'd0);
            if (q.size() == 0) chk("unexpected_ack", {30'd0, if_ack, dm_ack}, 32'd0);
            else begin
                e = q.pop_front();
                chk("ack_port", 32'(dm_ack), 32'(e.port));
                chk("ack_cycle", 32'(cyc), 32'(e.cyc));
                chk("dm_err", 32'(dm_err), 32'(e.err));
                chk("mem_addr", mem_addr, e.addr);
                chk("strobes", 32'(strobes), 32'(e.strobes));
                strobes = 0;
                if (e.rd) last_rd[e.port] = e.addr ^ K;
                chk("if_rdata", if_rdata, last_rd[0]);
                chk("dm_rdata", dm_rdata, last_rd[1]);
            end
        end
    end

    task automatic wait_done();
        logic gi, gd;
        for (int k = 0; k < 60 && (if_req || dm_req); k++) begin
            @(negedge clk);
            gi = if_ack;
            gd = dm_ack;
            @(posedge clk);
            #1;
            if (gi) if_req = 1'b0;
            if (gd) dm_req = 1'b0;
        end
        if (if_req || dm_req) begin
            vecs++;
            fails++;
            $display("FAIL timeout: if_req=%b dm_req=%b still waiting for ack", if_req, dm_req);
            if_req = 1'b0;
            dm_req = 1'b0;
            q.delete();
        end
    endtask

    task automatic do_vec(vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        busy_len = v.busy;
        if (v.is_dm) begin
            dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        e.port = v.is_dm; e.err = v.err; e.rd = !v.we && v.addr[1:0] == 2'b00;
        e.addr = v.addr; e.wdata = v.wdata; e.cyc = cyc + v.lat; e.strobes = v.strobes;
        q.push_back(e);
        wait_done();
    endtask

    task automatic do_pair(logic [31:0] ia, logic [31:0] da, logic dm_first);
        exp_t e;
        @(posedge clk);
        #1;
        busy_len = 0;
        if_req = 1'b1; if_addr = ia;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = da;
        e.err = 1'b0; e.rd = 1'b1; e.wdata = '0; e.strobes = 0;
        e.port = dm_first; e.addr = dm_first ? da : ia; e.cyc = cyc + 3;
        q.push_back(e);
        e.port = !dm_first; e.addr = dm_first ? ia : da; e.cyc = cyc + 7;
        q.push_back(e);
        wait_done();
    endtask

    task automatic rst_mid(int k);
        @(posedge clk);
        #1;
        busy_len = 20;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h500; dm_wdata = 32'hCAFE_F00D;
        repeat (k) @(posedge clk);
        #1;
        chk("pre_rst_strobe", 32'(mem_is_write), 32'(k == 1));
        chk("pre_rst_busy", 32'(mem_busy), 32'(k == 2));
        #1;
        rst = 1'b0;
        #1;
        chk("rst_ctl", {28'd0, mem_is_write, if_ack, dm_ack, dm_err}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_data_in", mem_data_in, 32'd0);
        chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
        dm_req = 1'b0; dm_we = 1'b0;
        strobes = 0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        last_rd[0] = '0;
        last_rd[1] = '0;
        vt[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,           0, 3, 1'b0, 0};
        vt[1] = '{1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678,   6, 9, 1'b0, 1};
        vt[2] = '{1'b1, 1'b0, 32'h0000_0102, 32'h0,           0, 1, 1'b1, 0};
        vt[3] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0,           0, 3, 1'b0, 0};
        vt[4] = '{1'b0, 1'b0, 32'h0000_0101, 32'h0,           0, 1, 1'b0, 0};
        vt[5] = '{1'b1, 1'b1, 32'h0000_0204, 32'hA5A5_A5A5,   0, 3, 1'b0, 1};
        vt[6] = '{1'b1, 1'b1, 32'h0000_0203, 32'h5555_AAAA,   0, 1, 1'b1, 0};
        vt[7] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,           0, 3, 1'b0, 0};
        vt[8] = '{1'b1, 1'b1, 32'h0000_0400, 32'h0F0F_0F0F,   2, 5, 1'b0, 1};
        vt[9] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,           0, 3, 1'b0, 0};
        #3;
        chk("reset_ctl", {28'd0, mem_is_write, if_ack, dm_ack, dm_err}, 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_mem_data_in", mem_data_in, 32'd0);
        chk("reset_rdata", if_rdata | dm_rdata, 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) do_vec(vt[i]);
        rst_mid(1);
        rst_mid(2);
        do_pair(32'h10, 32'h20, 1'b1);
        do_pair(32'h14, 32'h24, 1'b1);
        do_vec(vt[3]);
        do_pair(32'h18, 32'h28, 1'b0);
        do_vec(vt[1]);
        repeat (4) @(posedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule

// File: doc/phy_mem_arbiter.md
PHY_MEM_ARBITER -- requirements
Module: phy_mem_arbiter

Interface
REQ-001 Parameter READ_WAIT, default 1: extra wait cycles before read data is sampled; legal range 0..7.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 if_req  in  1  instruction-fetch read request; held high with stable if_addr until if_ack.
REQ-005 if_addr  in  32  fetch byte address.
REQ-006 if_rdata  out  32  fetch read data, valid while if_ack high.
REQ-007 if_ack  out  1  one-cycle completion pulse for the fetch port.
REQ-008 dm_req  in  1  data-port request; held high with stable dm_we/dm_addr/dm_wdata until dm_ack.
REQ-009 dm_we  in  1  1 = write, 0 = read.
REQ-010 dm_addr  in  32  data byte address.
REQ-011 dm_wdata  in  32  write data.
REQ-012 dm_rdata  out  32  read data, valid while dm_ack high.
REQ-013 dm_ack  out  1  one-cycle completion pulse for the data port.
REQ-014 dm_err  out  1  high with dm_ack when the request was rejected (unaligned).
REQ-015 mem_is_write  out  1  write strobe to the physical memory controller.
REQ-016 mem_addr  out  32  address to the controller.
REQ-017 mem_data_in  out  32  write data to the controller.
REQ-018 mem_data_out  in  32  read data from the controller.
REQ-019 mem_busy  in  1  controller busy; high while a write is in progress.

Function
REQ-020 FSM states SHALL be: IDLE, RD_WAIT, WR_ISSUE, WR_WAIT, DONE.
REQ-021 IDLE: no request -> stay. One request -> grant it. Both -> grant the port not granted last (last_owner flop); SHALL latch owner, we (forced 0 for fetch), addr, wdata.
REQ-022 IDLE grant, addr[1:0] != 0 -> DONE with error flag set, no memory access.
REQ-023 IDLE grant, aligned read -> RD_WAIT, wait counter = READ_WAIT; aligned write -> WR_ISSUE.
REQ-024 RD_WAIT: mem_is_write=0; counter != 0 -> decrement; counter == 0 and mem_busy=0 -> capture mem_data_out into owner's rdata register, go to DONE; mem_busy=1 -> hold.
REQ-025 WR_ISSUE: mem_is_write=1 for exactly one cycle, then WR_WAIT.
REQ-026 WR_WAIT: mem_is_write=0; go to DONE on first cycle with mem_busy=0.
REQ-027 DONE: owner's ack=1 for one cycle; dm_err = error flag when owner is DM, else 0; update last_owner; go to IDLE; no new grant in this cycle even if req is still high.
REQ-028 if_ack/dm_ack SHALL be decoded from state and owner only; never both high in one cycle.
REQ-029 mem_addr and mem_data_in SHALL always drive the latched addr/wdata (stable through whole transaction).
REQ-030 Aligned read latency, mem_busy=0: req seen in IDLE cycle N, ack in cycle N+READ_WAIT+2.
REQ-031 Aligned write latency: ack one cycle after first mem_busy=0 in WR_WAIT; minimum N+3.
REQ-032 if_rdata/dm_rdata SHALL hold their last captured value until the next capture for that port.
REQ-033 Requests dropped before ack are undefined usage; arbiter completes the latched transaction anyway.

Reset
REQ-034 rst low SHALL immediately force: state=IDLE, last_owner=IF (DM wins first tie), mem_is_write=0, all latches, rdata registers, acks, dm_err = 0.
REQ-035 Reset mid-transaction SHALL abandon it with no ack; mem_is_write drops same instant.

Verification
REQ-036 Fetch read, READ_WAIT=1, addr 0x100, mem_data_out=0xDEADBEEF -> if_ack at N+3, if_rdata=0xDEADBEEF, mem_is_write never high.
REQ-037 Both req together after reset -> DM granted first, then IF; subsequent simultaneous pairs alternate IF/DM.
REQ-038 DM write addr 0x200 data 0x12345678, mem_busy high 6 cycles after strobe -> one-cycle mem_is_write, mem_addr=0x200, mem_data_in=0x12345678, dm_ack one cycle after busy falls.
REQ-039 DM read addr 0x102 -> dm_ack=1 and dm_err=1 at N+1, no mem access, mem_addr changes but mem_is_write stays 0.
REQ-040 Assert rst low during WR_WAIT -> asynchronous return to IDLE, no ack, outputs zero; next request serviced normally.
